usb2_ulpi: RTL

ULPI link-layer front end sitting between the external ULPI PHY pins and `usb2_packet`. It demultiplexes the bidirectional ULPI bus into the packet layer's receive strobes (`in_act`/`in_byte`/`in_latch`) and RX CMD status. It muxes the packet layer's transmit stream (`out_byte`/`out_latch`/`out_stp`) onto the bus and returns `out_cts`/`out_nxt`. After reset it optionally programs the PHY Function Control register.

---
 rtl/usb2_ulpi.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/usb2_ulpi.sv
// usb2_ulpi: ULPI link front end between the PHY pins and usb2_packet.
// Define USB2_ULPI_REG_INIT_EN to write FUNC_CTRL into PHY Function Control after reset.
module usb2_ulpi #(
  parameter logic [7:0] FUNC_CTRL = 8'h40
) (
  input  logic       phy_clk,
  input  logic       reset_n,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  output logic       in_act,
  output logic [7:0] in_byte,
  output logic       in_latch,
  output logic       out_cts,
  output logic       out_nxt,
  input  logic [7:0] out_byte,
  input  logic       out_latch,
  input  logic       out_stp,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state,
  output logic       rx_err,
  output logic       tx_abort,
  output logic       init_done
);

  // state     | meaning
  // INIT_WAIT | stp held high until dir has been low for two cycles
  // INIT_CMD  | register-write command 0x84 on the bus, waiting for nxt
  // INIT_DATA | FUNC_CTRL on the bus, waiting for nxt
  // INIT_STP  | stp with 0x00 ends the register write
  // IDLE      | bus free, link may start a transmit
  // TX        | packet layer owns the bus
  // RX        | PHY owns the bus
  typedef enum logic [2:0] {
    INIT_WAIT, INIT_CMD, INIT_DATA, INIT_STP, IDLE, TX, RX
  } state_t;

  state_t state, state_nxt;
  logic   wait_cnt, wait_cnt_nxt;
  logic   set_done;
  logic   dir_q;
  logic   turn;

  assign turn         = ulpi_dir ^ dir_q;
  assign ulpi_data_oe = ~ulpi_dir;
  assign out_nxt      = ulpi_nxt & ~ulpi_dir & (state == TX);

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT_WAIT;
      wait_cnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    set_done      = 1'b0;
    ulpi_data_out = 8'h00;
    ulpi_stp      = 1'b0;
    case (state)
      INIT_WAIT: begin
        ulpi_stp = 1'b1;
        if (ulpi_dir) begin
          wait_cnt_nxt = 1'b1;
        end else if (wait_cnt == 1'b0) begin
          wait_cnt_nxt = 1'b1;
`ifdef USB2_ULPI_REG_INIT_EN
          state_nxt = INIT_CMD;
`else
          state_nxt = IDLE;
          set_done  = 1'b1;
`endif
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      INIT_CMD: begin
        ulpi_data_out = 8'h84;
        if (!ulpi_dir && ulpi_nxt) state_nxt = INIT_DATA;
      end
      INIT_DATA: begin
        ulpi_data_out = FUNC_CTRL;
        // PHY grabbed the bus mid-write: restart from the command byte once it lets go
        if (ulpi_dir)      state_nxt = INIT_CMD;
        else if (ulpi_nxt) state_nxt = INIT_STP;
      end
      INIT_STP: begin
        ulpi_stp  = 1'b1;
        set_done  = 1'b1;
        state_nxt = IDLE;
      end
      IDLE: begin
        if (ulpi_dir)                  state_nxt = RX;
        else if (out_latch && out_cts) state_nxt = TX;
      end
      TX: begin
        if (out_stp) ulpi_stp = 1'b1;
        else         ulpi_data_out = out_byte;
        if (ulpi_dir)     state_nxt = RX;
        else if (out_stp) state_nxt = IDLE;
      end
      RX: begin
        if (!ulpi_dir) state_nxt = IDLE;
      end
      default: state_nxt = INIT_WAIT;
    endcase
    // Never assert stp or data while the PHY drives, except the power-up stp hold
    if (ulpi_dir && state != INIT_WAIT) begin
      ulpi_data_out = 8'h00;
      ulpi_stp      = 1'b0;
    end
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q      <= 1'b0;
      in_act     <= 1'b0;
      in_byte    <= 8'h00;
      in_latch   <= 1'b0;
      line_state <= 2'b00;
      vbus_state <= 2'b00;
      rx_err     <= 1'b0;
      tx_abort   <= 1'b0;
      init_done  <= 1'b0;
      out_cts    <= 1'b0;
    end else begin
      dir_q    <= ulpi_dir;
      in_latch <= 1'b0;
      rx_err   <= 1'b0;
      tx_abort <= (state == TX) && ulpi_dir;
      out_cts  <= (state == IDLE) && !ulpi_dir && !in_act && init_done;
      if (set_done) init_done <= 1'b1;
      if (!ulpi_dir) begin
        in_act <= 1'b0;
      end else if (turn) begin
        // bus data is invalid in turnaround; nxt with the dir rise marks RX start
        if (ulpi_nxt) in_act <= 1'b1;
      end else if (ulpi_nxt) begin
        in_byte  <= ulpi_data_in;
        in_latch <= 1'b1;
      end else begin
        line_state <= ulpi_data_in[1:0];
        vbus_state <= ulpi_data_in[3:2];
        in_act     <= ulpi_data_in[4];
        rx_err     <= &ulpi_data_in[5:4];
      end
    end
  end

endmodule
